vga_timing_generator: RTL and testbench

Parametrised VGA raster timing generator; the next generation of `VgaController`. It produces hSync, vSync, displayActive and pixel coordinates for any timing set given as parameters. It also adds a pixel-enable input, programmable sync polarity, line/frame start strobes, and an output delay line that aligns sync with a downstream pixel pipeline. It sits between the pixel clock divider and the framebuffer fetch / DAC stages.

---
 rtl/vga_timing_pkg.sv | 38 +++
 rtl/vga_timing_generator_delay.sv | 33 +++
 rtl/vga_timing_generator.sv | 107 ++++++++++
 tb/tb_vga_timing_generator.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, the porch/sync bundle type and the counter-width check
// used by the raster generator.
package vga_timing_pkg;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FRONT  = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BACK   = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FRONT  = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BACK   = 33;

  typedef struct packed {
    int unsigned hActive;
    int unsigned hFront;
    int unsigned hSync;
    int unsigned hBack;
    int unsigned vActive;
    int unsigned vFront;
    int unsigned vSync;
    int unsigned vBack;
  } vga_timing_t;

  function automatic int unsigned hTotal(vga_timing_t t);
    return t.hActive + t.hFront + t.hSync + t.hBack;
  endfunction

  function automatic int unsigned vTotal(vga_timing_t t);
    return t.vActive + t.vFront + t.vSync + t.vBack;
  endfunction

  // A counter of `width` bits can hold 0..total-1.
  function automatic bit fitsWidth(int unsigned total, int width);
    return (total > 0) && ($clog2(total) <= width);
  endfunction

endpackage

// File: rtl/vga_timing_generator_delay.sv
// Enable-gated shift register; every stage loads RST_VAL on reset.
module vga_delay_line #(
  parameter int                 DEPTH   = 0,
  parameter int                 WIDTH   = 1,
  parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : gWire
    logic unusedCtl;
    assign unusedCtl = ^{clk, rst, en};
    assign dout = din;
  end else begin : gShift
    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
      end else if (en) begin
        stage[0] <= din;
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign dout = stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_generator.sv
// Parametrised VGA raster generator: pixel counters, registered sync/active decode
// and an enable-gated delay line that aligns sync with a downstream pixel pipeline.
module vga_timing_generator
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
  parameter int unsigned H_FRONT    = DEF_H_FRONT,
  parameter int unsigned H_SYNC     = DEF_H_SYNC,
  parameter int unsigned H_BACK     = DEF_H_BACK,
  parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
  parameter int unsigned V_FRONT    = DEF_V_FRONT,
  parameter int unsigned V_SYNC     = DEF_V_SYNC,
  parameter int unsigned V_BACK     = DEF_V_BACK,
  parameter bit          H_POL      = 1'b0,
  parameter bit          V_POL      = 1'b0,
  parameter int          COL_W      = 10,
  parameter int          ROW_W      = 10,
  parameter int          PIPE_DELAY = 0
) (
  input  logic             clkDiv,
  input  logic             rst,
  input  logic             pixelEnable,
  output logic             hSync,
  output logic             vSync,
  output logic             displayActive,
  output logic [COL_W-1:0] column,
  output logic [ROW_W-1:0] row,
  output logic             lineStart,
  output logic             frameStart
);

  localparam vga_timing_t TIMING = '{
    hActive: H_ACTIVE, hFront: H_FRONT, hSync: H_SYNC, hBack: H_BACK,
    vActive: V_ACTIVE, vFront: V_FRONT, vSync: V_SYNC, vBack: V_BACK
  };

  if (!fitsWidth(hTotal(TIMING), COL_W)) begin : gColWidthErr
    $error("vga_timing_generator: H_TOTAL does not fit in COL_W bits");
  end
  if (!fitsWidth(vTotal(TIMING), ROW_W)) begin : gRowWidthErr
    $error("vga_timing_generator: V_TOTAL does not fit in ROW_W bits");
  end
  if (PIPE_DELAY < 0 || PIPE_DELAY > 15) begin : gDelayErr
    $error("vga_timing_generator: PIPE_DELAY must be within 0..15");
  end

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(hTotal(TIMING) - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(vTotal(TIMING) - 1);
  localparam logic [COL_W-1:0] H_ACT    = COL_W'(TIMING.hActive);
  localparam logic [COL_W-1:0] HS_START = COL_W'(TIMING.hActive + TIMING.hFront);
  localparam logic [COL_W-1:0] HS_END   = COL_W'(TIMING.hActive + TIMING.hFront + TIMING.hSync);
  localparam logic [ROW_W-1:0] V_ACT    = ROW_W'(TIMING.vActive);
  localparam logic [ROW_W-1:0] VS_START = ROW_W'(TIMING.vActive + TIMING.vFront);
  localparam logic [ROW_W-1:0] VS_END   = ROW_W'(TIMING.vActive + TIMING.vFront + TIMING.vSync);

  logic [COL_W-1:0] colNext;
  logic [ROW_W-1:0] rowNext;
  logic             hLvl_p0, vLvl_p0, active_p0;
  logic [2:0]       syncBus_p1;

  always_comb begin
    colNext = (column == COL_LAST) ? '0 : column + COL_W'(1);
    rowNext = row;
    if (column == COL_LAST) rowNext = (row == ROW_LAST) ? '0 : row + ROW_W'(1);
  end

  // Stage p0: counters and decode of the position they move to, so every
  // registered flag describes the column/row presented alongside it.
  always_ff @(posedge clkDiv) begin
    if (rst) begin
      column     <= COL_LAST;
      row        <= ROW_LAST;
      hLvl_p0    <= ~H_POL;
      vLvl_p0    <= ~V_POL;
      active_p0  <= 1'b0;
      lineStart  <= 1'b0;
      frameStart <= 1'b0;
    end else if (pixelEnable) begin
      column     <= colNext;
      row        <= rowNext;
      hLvl_p0    <= (colNext >= HS_START && colNext < HS_END) ? H_POL : ~H_POL;
      vLvl_p0    <= (rowNext >= VS_START && rowNext < VS_END) ? V_POL : ~V_POL;
      active_p0  <= (colNext < H_ACT) && (rowNext < V_ACT);
      lineStart  <= (colNext == '0);
      frameStart <= (colNext == '0) && (rowNext == '0);
    end else begin
      lineStart  <= 1'b0;
      frameStart <= 1'b0;
    end
  end

  // Stage p1: optional alignment delay for the sync/active bundle.
  vga_delay_line #(
    .DEPTH   (PIPE_DELAY),
    .WIDTH   (3),
    .RST_VAL ({~H_POL, ~V_POL, 1'b0})
  ) uSyncDelay (
    .clk  (clkDiv),
    .rst  (rst),
    .en   (pixelEnable),
    .din  ({hLvl_p0, vLvl_p0, active_p0}),
    .dout (syncBus_p1)
  );

  assign {hSync, vSync, displayActive} = syncBus_p1;

endmodule

// File: tb/tb_vga_timing_generator.sv
// Bench for vga_timing_generator: three configurations driven in lockstep, a behavioural
// scoreboard per configuration, plus scenario-level timing measurements.
module tb_vga_timing_generator;

  typedef struct packed {
    logic [9:0] col;
    logic [9:0] row;
    logic       hs, vs, da, ls, fs;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pixelEnable = 1'b0;

  logic [9:0] col0, row0, col2, row2;
  logic [4:0] col1, row1;
  logic hs0, vs0, da0, ls0, fs0;
  logic hs1, vs1, da1, ls1, fs1;
  logic hs2, vs2, da2, ls2, fs2;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  exp_t q0[$], q1[$], q2[$];

  // Model configuration: dut0 default, dut1 small with delay/polarity, dut2 default with delay/polarity.
  int hA[3] = '{640, 8, 640};
  int hF[3] = '{16, 2, 16};
  int hS[3] = '{96, 3, 96};
  int hB[3] = '{48, 3, 48};
  int vA[3] = '{480, 4, 480};
  int vF[3] = '{10, 1, 10};
  int vS[3] = '{2, 1, 2};
  int vB[3] = '{33, 1, 33};
  int dly[3] = '{0, 3, 3};
  bit hp[3] = '{1'b0, 1'b1, 1'b1};
  bit vp[3] = '{1'b0, 1'b1, 1'b1};

  int mc[3], mr[3];
  bit uh[3], uv[3], ua[3], mls[3], mfs[3];
  bit dh[3][16], dv[3][16], dA[3][16];

  always #5 clk = ~clk;

  vga_timing_generator dut0 (
    .clkDiv(clk), .rst(rst), .pixelEnable(pixelEnable),
    .hSync(hs0), .vSync(vs0), .displayActive(da0),
    .column(col0), .row(row0), .lineStart(ls0), .frameStart(fs0)
  );

  vga_timing_generator #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .H_POL(1'b1), .V_POL(1'b1), .COL_W(5), .ROW_W(5), .PIPE_DELAY(3)
  ) dut1 (
    .clkDiv(clk), .rst(rst), .pixelEnable(pixelEnable),
    .hSync(hs1), .vSync(vs1), .displayActive(da1),
    .column(col1), .row(row1), .lineStart(ls1), .frameStart(fs1)
  );

  vga_timing_generator #(
    .H_POL(1'b1), .V_POL(1'b1), .PIPE_DELAY(3)
  ) dut2 (
    .clkDiv(clk), .rst(rst), .pixelEnable(pixelEnable),
    .hSync(hs2), .vSync(vs2), .displayActive(da2),
    .column(col2), .row(row2), .lineStart(ls2), .frameStart(fs2)
  );

  task automatic modelStep(input bit pe, input bit r);
    for (int i = 0; i < 3; i++) begin
      int ht, vt;
      exp_t e;
      bit oh, ov, oa;
      ht = hA[i] + hF[i] + hS[i] + hB[i];
      vt = vA[i] + vF[i] + vS[i] + vB[i];
      if (r) begin
        mc[i] = ht - 1; mr[i] = vt - 1;
        uh[i] = 0; uv[i] = 0; ua[i] = 0; mls[i] = 0; mfs[i] = 0;
        for (int j = 0; j < 16; j++) begin dh[i][j] = 0; dv[i][j] = 0; dA[i][j] = 0; end
      end else if (pe) begin
        for (int j = 15; j > 0; j--) begin
          dh[i][j] = dh[i][j-1]; dv[i][j] = dv[i][j-1]; dA[i][j] = dA[i][j-1];
        end
        dh[i][0] = uh[i]; dv[i][0] = uv[i]; dA[i][0] = ua[i];
        mc[i]++;
        if (mc[i] == ht) begin
          mc[i] = 0;
          mr[i]++;
          if (mr[i] == vt) mr[i] = 0;
        end
        uh[i] = (mc[i] >= hA[i] + hF[i]) && (mc[i] < hA[i] + hF[i] + hS[i]);
        uv[i] = (mr[i] >= vA[i] + vF[i]) && (mr[i] < vA[i] + vF[i] + vS[i]);
        ua[i] = (mc[i] < hA[i]) && (mr[i] < vA[i]);
        mls[i] = (mc[i] == 0);
        mfs[i] = (mc[i] == 0) && (mr[i] == 0);
      end else begin
        mls[i] = 0; mfs[i] = 0;
      end
      oh = (dly[i] == 0) ? uh[i] : dh[i][dly[i]-1];
      ov = (dly[i] == 0) ? uv[i] : dv[i][dly[i]-1];
      oa = (dly[i] == 0) ? ua[i] : dA[i][dly[i]-1];
      e.col = 10'(mc[i]); e.row = 10'(mr[i]);
      e.hs = oh ? hp[i] : ~hp[i];
      e.vs = ov ? vp[i] : ~vp[i];
      e.da = oa; e.ls = mls[i]; e.fs = mfs[i];
      case (i)
        0: q0.push_back(e);
        1: q1.push_back(e);
        default: q2.push_back(e);
      endcase
    end
  endtask

  task automatic tick(input bit pe, input bit r);
    pixelEnable = pe;
    rst = r;
    modelStep(pe, r);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic exp_t popExp(int k);
    exp_t e;
    e = '1;
    case (k)
      0: if (q0.size() > 0) e = q0.pop_front();
      1: if (q1.size() > 0) e = q1.pop_front();
      default: if (q2.size() > 0) e = q2.pop_front();
    endcase
    return e;
  endfunction

  function automatic exp_t obs(int k);
    exp_t o;
    case (k)
      0: o = '{col0, row0, hs0, vs0, da0, ls0, fs0};
      1: o = '{10'(col1), 10'(row1), hs1, vs1, da1, ls1, fs1};
      default: o = '{col2, row2, hs2, vs2, da2, ls2, fs2};
    endcase
    return o;
  endfunction

  task automatic test_reset;
    for (int n = 0; n < 3; n++) begin
      tick(n[0], 1'b1);
      for (int k = 0; k < 3; k++) begin
        exp_t e, o;
        e = popExp(k); o = obs(k); total++;
        if (o !== e) begin
          bad++;
          $display("FAIL reset_sb dut%0d got col=%0d row=%0d hvdlf=%b want col=%0d row=%0d hvdlf=%b",
                   k, o.col, o.row, {o.hs, o.vs, o.da, o.ls, o.fs}, e.col, e.row, {e.hs, e.vs, e.da, e.ls, e.fs});
        end
      end
    end
    total++;
    if ({col0, row0, hs0, vs0, da0, ls0, fs0} !== {10'd799, 10'd524, 5'b11000}) begin
      bad++;
      $display("FAIL reset_default got col=%0d row=%0d hvdlf=%b want col=799 row=524 hvdlf=11000",
               col0, row0, {hs0, vs0, da0, ls0, fs0});
    end
    total++;
    if ({col1, row1, hs1, vs1, da1} !== {5'd15, 5'd6, 3'b000}) begin
      bad++;
      $display("FAIL reset_small got col=%0d row=%0d hvd=%b want col=15 row=6 hvd=000",
               col1, row1, {hs1, vs1, da1});
    end
  endtask

  task automatic test_first_pixel;
    tick(1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      exp_t e, o;
      e = popExp(k); o = obs(k); total++;
      if (o !== e) begin
        bad++;
        $display("FAIL first_sb dut%0d got col=%0d row=%0d hvdlf=%b want col=%0d row=%0d hvdlf=%b",
                 k, o.col, o.row, {o.hs, o.vs, o.da, o.ls, o.fs}, e.col, e.row, {e.hs, e.vs, e.da, e.ls, e.fs});
      end
    end
    total++;
    if ({col0, row0, da0, ls0, fs0} !== {10'd0, 10'd0, 3'b111}) begin
      bad++;
      $display("FAIL first_pixel got col=%0d row=%0d dlf=%b want col=0 row=0 dlf=111",
               col0, row0, {da0, ls0, fs0});
    end
    total++;
    if ({da2, fs2} !== 2'b01) begin
      bad++;
      $display("FAIL first_pixel_delayed got da=%b fs=%b want da=0 fs=1", da2, fs2);
    end
  endtask

  task automatic test_hsync;
    int fall1, fall2, rise1, fallCol, t656, rise2, daCnt, ls1c, ls2c;
    logic p0, p2;
    fall1 = -1; fall2 = -1; rise1 = -1; fallCol = -1; t656 = -1; rise2 = -1;
    daCnt = 0; ls1c = -1; ls2c = -1;
    p0 = hs0; p2 = hs2;
    for (int n = 0; n < 1600; n++) begin
      tick(1'b1, 1'b0);
      for (int k = 0; k < 3; k++) begin
        exp_t e, o;
        e = popExp(k); o = obs(k); total++;
        if (o !== e) begin
          bad++;
          $display("FAIL hsync_sb dut%0d got col=%0d row=%0d hvdlf=%b want col=%0d row=%0d hvdlf=%b",
                   k, o.col, o.row, {o.hs, o.vs, o.da, o.ls, o.fs}, e.col, e.row, {e.hs, e.vs, e.da, e.ls, e.fs});
        end
      end
      if (p0 === 1'b1 && hs0 === 1'b0) begin
        if (fall1 < 0) begin fall1 = cyc; fallCol = int'(col0); end
        else if (fall2 < 0) fall2 = cyc;
      end
      if (p0 === 1'b0 && hs0 === 1'b1 && fall1 >= 0 && rise1 < 0) rise1 = cyc;
      if (col2 == 10'd656 && t656 < 0) t656 = cyc;
      if (p2 === 1'b0 && hs2 === 1'b1 && rise2 < 0) rise2 = cyc;
      if (da0 === 1'b1) daCnt++;
      if (ls0 === 1'b1) begin
        if (ls1c < 0) ls1c = cyc; else if (ls2c < 0) ls2c = cyc;
      end
      p0 = hs0; p2 = hs2;
    end
    total++;
    if (fallCol != 656) begin bad++; $display("FAIL hsync_start_col got %0d want 656", fallCol); end
    total++;
    if (rise1 - fall1 != 96) begin bad++; $display("FAIL hsync_width got %0d want 96", rise1 - fall1); end
    total++;
    if (fall2 - fall1 != 800) begin bad++; $display("FAIL hsync_period got %0d want 800", fall2 - fall1); end
    total++;
    if (ls2c - ls1c != 800 || ls1c < 0) begin
      bad++; $display("FAIL linestart_period got %0d want 800", ls2c - ls1c);
    end
    total++;
    if (daCnt != 1280) begin bad++; $display("FAIL active_count got %0d want 1280", daCnt); end
    total++;
    if (rise2 - t656 != 3 || t656 < 0) begin
      bad++; $display("FAIL hsync_delay3 got %0d want 3", rise2 - t656);
    end
  endtask

  task automatic test_pe_toggle;
    int fall, rise, lsA, lsB;
    logic [9:0] colPrev;
    logic p0;
    fall = -1; rise = -1; lsA = -1; lsB = -1;
    p0 = 1'b1;
    for (int n = 0; n < 3203; n++) begin
      bit pe, r;
      r = (n < 2);
      pe = (n == 2) ? 1'b1 : ((n >= 3) ? 1'((n - 3) & 1) : 1'b0);
      colPrev = col0;
      tick(pe, r);
      for (int k = 0; k < 3; k++) begin
        exp_t e, o;
        e = popExp(k); o = obs(k); total++;
        if (o !== e) begin
          bad++;
          $display("FAIL petoggle_sb dut%0d got col=%0d row=%0d hvdlf=%b want col=%0d row=%0d hvdlf=%b",
                   k, o.col, o.row, {o.hs, o.vs, o.da, o.ls, o.fs}, e.col, e.row, {e.hs, e.vs, e.da, e.ls, e.fs});
        end
      end
      if (n >= 3 && !pe) begin
        total++;
        if (col0 !== colPrev) begin
          bad++; $display("FAIL frozen_col got %0d want %0d", col0, colPrev);
        end
      end
      if (n >= 3) begin
        if (p0 === 1'b1 && hs0 === 1'b0 && fall < 0) fall = cyc;
        if (p0 === 1'b0 && hs0 === 1'b1 && fall >= 0 && rise < 0) rise = cyc;
        if (ls0 === 1'b1) begin
          if (lsA < 0) lsA = cyc; else if (lsB < 0) lsB = cyc;
        end
      end
      p0 = hs0;
    end
    total++;
    if (rise - fall != 192 || fall < 0) begin
      bad++; $display("FAIL half_rate_hsync_width got %0d want 192", rise - fall);
    end
    total++;
    if (lsB - lsA != 1600 || lsA < 0) begin
      bad++; $display("FAIL half_rate_line_period got %0d want 1600", lsB - lsA);
    end
  endtask

  task automatic test_reset_mid;
    for (int n = 0; n < 2306; n++) begin
      bit pe, r;
      r = (n < 2) || (n == 2303) || (n == 2304);
      pe = (n >= 2) && (n != 2303);
      tick(pe, r);
      for (int k = 0; k < 3; k++) begin
        exp_t e, o;
        e = popExp(k); o = obs(k); total++;
        if (o !== e) begin
          bad++;
          $display("FAIL resetmid_sb dut%0d got col=%0d row=%0d hvdlf=%b want col=%0d row=%0d hvdlf=%b",
                   k, o.col, o.row, {o.hs, o.vs, o.da, o.ls, o.fs}, e.col, e.row, {e.hs, e.vs, e.da, e.ls, e.fs});
        end
      end
      if (n == 2302) begin
        total++;
        if ({col0, row0, hs0} !== {10'd700, 10'd2, 1'b0}) begin
          bad++; $display("FAIL pre_reset_pos got col=%0d row=%0d hs=%b want col=700 row=2 hs=0", col0, row0, hs0);
        end
      end
      if (n == 2303 || n == 2304) begin
        total++;
        if ({col0, row0, hs0, vs0, da0, fs0, hs2, da2} !== {10'd799, 10'd524, 6'b110000}) begin
          bad++;
          $display("FAIL mid_reset got col=%0d row=%0d hvdf=%b hs2=%b da2=%b want col=799 row=524 hvdf=1100 hs2=0 da2=0",
                   col0, row0, {hs0, vs0, da0, fs0}, hs2, da2);
        end
      end
      if (n == 2305) begin
        total++;
        if ({col0, row0, fs0, hs0} !== {10'd0, 10'd0, 2'b11}) begin
          bad++; $display("FAIL post_reset got col=%0d row=%0d fs=%b hs=%b want col=0 row=0 fs=1 hs=1", col0, row0, fs0, hs0);
        end
      end
    end
  endtask

  task automatic test_small_frame;
    int fsA, fsB, t10, hRise, tv, vRise, hCnt, vCnt, dCnt;
    logic ph, pv;
    fsA = -1; fsB = -1; t10 = -1; hRise = -1; tv = -1; vRise = -1;
    hCnt = 0; vCnt = 0; dCnt = 0;
    ph = 1'b0; pv = 1'b0;
    for (int n = 0; n < 226; n++) begin
      tick(n >= 2, n < 2);
      for (int k = 0; k < 3; k++) begin
        exp_t e, o;
        e = popExp(k); o = obs(k); total++;
        if (o !== e) begin
          bad++;
          $display("FAIL small_sb dut%0d got col=%0d row=%0d hvdlf=%b want col=%0d row=%0d hvdlf=%b",
                   k, o.col, o.row, {o.hs, o.vs, o.da, o.ls, o.fs}, e.col, e.row, {e.hs, e.vs, e.da, e.ls, e.fs});
        end
      end
      if (n >= 2) begin
        if (fs1 === 1'b1) begin
          if (fsA < 0) fsA = cyc; else if (fsB < 0) fsB = cyc;
        end
        if (col1 == 5'd10 && t10 < 0) t10 = cyc;
        if (row1 == 5'd5 && col1 == 5'd0 && tv < 0) tv = cyc;
        if (ph === 1'b0 && hs1 === 1'b1 && hRise < 0) hRise = cyc;
        if (pv === 1'b0 && vs1 === 1'b1 && vRise < 0) vRise = cyc;
        if (hs1 === 1'b1) hCnt++;
        if (vs1 === 1'b1) vCnt++;
        if (da1 === 1'b1) dCnt++;
      end
      ph = hs1; pv = vs1;
    end
    total++;
    if (fsB - fsA != 112 || fsA < 0) begin bad++; $display("FAIL small_frame_period got %0d want 112", fsB - fsA); end
    total++;
    if (hRise - t10 != 3 || t10 < 0) begin bad++; $display("FAIL small_hsync_delay got %0d want 3", hRise - t10); end
    total++;
    if (vRise - tv != 3 || tv < 0) begin bad++; $display("FAIL small_vsync_delay got %0d want 3", vRise - tv); end
    total++;
    if (hCnt != 42) begin bad++; $display("FAIL small_hsync_count got %0d want 42", hCnt); end
    total++;
    if (vCnt != 32) begin bad++; $display("FAIL small_vsync_count got %0d want 32", vCnt); end
    total++;
    if (dCnt != 64) begin bad++; $display("FAIL small_active_count got %0d want 64", dCnt); end
  endtask

  initial begin
    test_reset();
    test_first_pixel();
    test_hsync();
    test_pe_toggle();
    test_reset_mid();
    test_small_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
